power_rail_sequencer: RTL
=========================

Name: power_rail_sequencer

Overview:
- Sequences the two board power rails driven by the power_control export. Brings them up in order and verifies each against its power_sense group.
- Shuts the rails down in reverse order and latches a fault if a rail does not come up or drops while on.
- Sits in the FPGA fabric between an HPS-written control register (enable/clear bits) and the power_control/power_sense pins.

Parameters:
- SETTLE_CYCLES, 50000: cycles to hold after a rail is good, and between rail-off steps.
- TIMEOUT_CYCLES, 5000000: maximum cycles to wait for a rail's sense group to go good.
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronized sense bit must differ before its debounced value flips.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable_req  in  1  level; 1 = rails requested on.
- fault_clear  in  1  single-cycle pulse; clears a latched fault.
- power_sense  in  6  asynchronous rail-good inputs. Bits [2:0] = rail 0 group, bits [5:3] = rail 1 group.
- power_control  out  2  rail enables; bit0 = rail 0, bit1 = rail 1.
- power_good  out  1  1 only in state ON.
- fault  out  1  latched fault flag.
- fault_code  out  8  latched cause: {state_at_fault[3:0], cause[3:0]}.
- seq_state  out  4  current FSM state encoding.

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0, state IDLE, counters 0.
  - Debounced sense register 0; 2-flop synchronizer flops 0.
- Input conditioning:
  - power_sense passes through a 2-flop synchronizer, then a per-bit debouncer.
  - A debounced bit flips only after the synchronized bit differs from it for DEBOUNCE_CYCLES consecutive cycles. The per-bit counter resets whenever the values match.
  - grp0 = AND of debounced[2:0]; grp1 = AND of debounced[5:3].
- FSM states and encodings: IDLE=0, EN0=1, SETTLE0=2, EN1=3, SETTLE1=4, ON=5, DOWN1=6, DOWN0=7, FAULT=8. All outputs are registered.
  - IDLE: power_control=00. enable_req=1 & fault=0 -> EN0 and clear the counter.
  - EN0: power_control=01.
    - grp0=1 -> SETTLE0.
    - Counter reaches TIMEOUT_CYCLES-1 -> FAULT with cause=1.
    - enable_req=0 -> DOWN0.
  - SETTLE0: power_control=01. Counter reaches SETTLE_CYCLES-1 -> EN1. grp0=0 -> FAULT with cause=2.
  - EN1: power_control=11.
    - grp1=1 -> SETTLE1.
    - Timeout -> FAULT with cause=3.
    - grp0=0 -> FAULT with cause=2.
  - SETTLE1: power_control=11. Counter done -> ON. Any group low -> FAULT, cause=2 (grp0) or 4 (grp1); grp0 takes priority.
  - ON: power_control=11, power_good=1.
    - grp0=0 or grp1=0 -> FAULT with cause 2/4.
    - Otherwise enable_req=0 -> DOWN1.
    - Fault takes priority over the enable drop.
  - DOWN1: power_control=01 for SETTLE_CYCLES, then DOWN0.
  - DOWN0: power_control=00 for SETTLE_CYCLES, then IDLE.
  - enable_req dropping during SETTLE0/EN1/SETTLE1 -> DOWN1 (or DOWN0 if rail 1 was never enabled, i.e. from SETTLE0).
  - FAULT:
    - power_control=00 starting in the first cycle in FAULT, with no reverse ordering.
    - fault=1. fault_code is latched on entry and held.
    - fault_clear=1 & enable_req=0 -> IDLE; fault and fault_code both clear to 0.
    - fault_clear while enable_req=1 is ignored.
- Counter:
  - Single shared counter of width clog2(max(TIMEOUT_CYCLES, SETTLE_CYCLES)).
  - Cleared on every state change; saturates, never wraps.
- Simultaneous events:
  - Fault detection beats timeout beats enable change.
  - fault_clear outside FAULT has no effect.
- Reset mid-sequence: power_control drops to 00 asynchronously. There is no shutdown ordering under reset.

Test Plan (SETTLE_CYCLES=8, TIMEOUT_CYCLES=32, DEBOUNCE_CYCLES=4):
1. Power-up: enable_req=1, sense[2:0]=111 at cycle 5 and sense[5:3]=111 at cycle 20.
   - power_control: 01 at cycle 2, 11 after the SETTLE0 dwell, power_good=1 after SETTLE1.
   - seq_state walks 0→1→2→3→4→5; fault=0.
2. Timeout: enable_req=1, sense held 000000.
   - 32 cycles after entering EN0: fault=1, fault_code=0x11, power_control=00.
3. Glitch rejection: in ON, pulse sense[4]=0 for 3 cycles -> no change.
   - Hold sense[4]=0 for 4+ cycles -> FAULT with fault_code=0x54 and power_control=00.
4. Orderly shutdown: in ON, drop enable_req.
   - power_control=01 for 8 cycles, then 00 for 8 cycles, then seq_state=0; power_good=0 from DOWN1.
5. Fault clear:
   - In FAULT, fault_clear with enable_req=1 -> still FAULT.
   - Drop enable_req, then fault_clear -> IDLE with fault=0 and fault_code=0x00.
6. Async reset asserted in SETTLE1 -> power_control=00, seq_state=0 and all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/power_rail_sequencer.sv
// Two-rail power sequencer: ordered bring-up, reverse-order shutdown, latched faults.
module power_rail_sequencer #(
  parameter int unsigned SETTLE_CYCLES   = 50000,
  parameter int unsigned TIMEOUT_CYCLES  = 5000000,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable_req,
  input  logic       fault_clear,
  input  logic [5:0] power_sense,
  output logic [1:0] power_control,
  output logic       power_good,
  output logic       fault,
  output logic [7:0] fault_code,
  output logic [3:0] seq_state
);

  localparam int unsigned SENSE_W = 6;
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_EN0     = 4'd1;
  localparam logic [3:0] ST_SETTLE0 = 4'd2;
  localparam logic [3:0] ST_EN1     = 4'd3;
  localparam logic [3:0] ST_SETTLE1 = 4'd4;
  localparam logic [3:0] ST_ON      = 4'd5;
  localparam logic [3:0] ST_DOWN1   = 4'd6;
  localparam logic [3:0] ST_DOWN0   = 4'd7;
  localparam logic [3:0] ST_FAULT   = 4'd8;

  localparam logic [3:0] CAUSE_NONE     = 4'd0;
  localparam logic [3:0] CAUSE_TMO0     = 4'd1;
  localparam logic [3:0] CAUSE_LOST0    = 4'd2;
  localparam logic [3:0] CAUSE_TMO1     = 4'd3;
  localparam logic [3:0] CAUSE_LOST1    = 4'd4;

  logic [SENSE_W-1:0] sync_q1, sync_q2, deb_q;
  logic [DB_W-1:0]    db_cnt_q [SENSE_W];
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         state_q, state_nxt, cause_nxt;
  logic [1:0]         pc_nxt;
  logic               grp0, grp1, tmo_done, settle_done;

  // Two-flop synchronizer for the asynchronous sense pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= power_sense;
      sync_q2 <= sync_q1;
    end
  end

  // Per-bit debouncer: flip only after DEBOUNCE_CYCLES consecutive disagreements
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q <= '0;
      for (int i = 0; i < int'(SENSE_W); i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(SENSE_W); i++) begin
        if (sync_q2[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          deb_q[i]    <= sync_q2[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign grp0        = &deb_q[2:0];
  assign grp1        = &deb_q[5:3];
  assign tmo_done    = (cnt_q == TMO_LAST);
  assign settle_done = (cnt_q == SETTLE_LAST);

  // Next-state logic; rail loss beats timeout/settle beats enable drop
  always_comb begin
    state_nxt = state_q;
    cause_nxt = CAUSE_NONE;
    case (state_q)
      ST_IDLE: if (enable_req && !fault) state_nxt = ST_EN0;
      ST_EN0: begin
        if (grp0)             state_nxt = ST_SETTLE0;
        else if (tmo_done)    begin state_nxt = ST_FAULT; cause_nxt = CAUSE_TMO0; end
        else if (!enable_req) state_nxt = ST_DOWN0;
      end
      ST_SETTLE0: begin
        if (!grp0)            begin state_nxt = ST_FAULT; cause_nxt = CAUSE_LOST0; end
        else if (settle_done) state_nxt = ST_EN1;
        else if (!enable_req) state_nxt = ST_DOWN0;
      end
      ST_EN1: begin
        if (!grp0)            begin state_nxt = ST_FAULT; cause_nxt = CAUSE_LOST0; end
        else if (grp1)        state_nxt = ST_SETTLE1;
        else if (tmo_done)    begin state_nxt = ST_FAULT; cause_nxt = CAUSE_TMO1; end
        else if (!enable_req) state_nxt = ST_DOWN1;
      end
      ST_SETTLE1: begin
        if (!grp0)            begin state_nxt = ST_FAULT; cause_nxt = CAUSE_LOST0; end
        else if (!grp1)       begin state_nxt = ST_FAULT; cause_nxt = CAUSE_LOST1; end
        else if (settle_done) state_nxt = ST_ON;
        else if (!enable_req) state_nxt = ST_DOWN1;
      end
      ST_ON: begin
        if (!grp0)            begin state_nxt = ST_FAULT; cause_nxt = CAUSE_LOST0; end
        else if (!grp1)       begin state_nxt = ST_FAULT; cause_nxt = CAUSE_LOST1; end
        else if (!enable_req) state_nxt = ST_DOWN1;
      end
      ST_DOWN1: if (settle_done) state_nxt = ST_DOWN0;
      ST_DOWN0: if (settle_done) state_nxt = ST_IDLE;
      ST_FAULT: if (fault_clear && !enable_req) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Rail enables implied by the upcoming state
  always_comb begin
    pc_nxt = 2'b00;
    case (state_nxt)
      ST_EN0, ST_SETTLE0, ST_DOWN1: pc_nxt = 2'b01;
      ST_EN1, ST_SETTLE1, ST_ON:    pc_nxt = 2'b11;
      default:                      pc_nxt = 2'b00;
    endcase
  end

  // State, shared saturating counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      power_control <= 2'b00;
      power_good    <= 1'b0;
      fault         <= 1'b0;
      fault_code    <= 8'h00;
    end else begin
      state_q       <= state_nxt;
      if (state_nxt != state_q) cnt_q <= '0;
      else if (cnt_q != '1)     cnt_q <= cnt_q + CNT_W'(1);
      power_control <= pc_nxt;
      power_good    <= (state_nxt == ST_ON);
      fault         <= (state_nxt == ST_FAULT);
      if (state_nxt == ST_FAULT && state_q != ST_FAULT) fault_code <= {state_q, cause_nxt};
      else if (state_nxt != ST_FAULT)                   fault_code <= 8'h00;
    end
  end

  assign seq_state = state_q;

endmodule
